// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory path: loader FSM encoding,
// the HALT opcode word and the address-width helper used by loader and memory.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2,
      ST_DONE = 2'd3
   } loader_state_t;

   localparam logic [15:0] HALT_WORD = 16'h0000;

   // Ceiling log2; a depth of 1 still yields a 1-bit address.
   function automatic int clogb2(input int depth);
      int r;
      r = 0;
      while ((1 << r) < depth) r = r + 1;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/instruction_loader.sv
// Assembles host bytes (high first) into instruction words and writes them to consecutive
// memory addresses from 0; one registered write strobe per word, stops on HALT or memory full.
import mips_pkg::*;

module instruction_loader #(
   parameter int NB_DATA            = 16,
   parameter int NB_BYTE            = 8,
   parameter int N_ADDR             = 2048,
   parameter int LOG2_N_INSMEM_ADDR = clogb2(N_ADDR)
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_start,
   input  logic [NB_BYTE-1:0]            i_rx_data,
   input  logic                          i_rx_valid,
   output logic [NB_DATA-1:0]            o_wr_data,
   output logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr,
   output logic                          o_wr_enable,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_error,
   output logic [LOG2_N_INSMEM_ADDR:0]   o_word_count
);

   localparam int PTR_W = LOG2_N_INSMEM_ADDR + 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_ADDR - 1);

   loader_state_t r_state;
   loader_state_t w_next_state;

   logic [NB_BYTE-1:0]            r_hi_byte;
   logic [PTR_W-1:0]              r_ptr;
   logic                          r_error;
   logic [NB_DATA-1:0]            r_wr_data;
   logic [LOG2_N_INSMEM_ADDR-1:0] r_wr_addr;
   logic                          r_wr_enable;

   logic [NB_DATA-1:0] w_word;
   logic               w_is_halt;
   logic               w_at_last;
   logic               w_load_start;
   logic               w_latch_hi;
   logic               w_write;
   logic               w_set_error;
   logic               w_busy;
   logic               w_done;

   assign w_word    = {r_hi_byte, i_rx_data};
   assign w_is_halt = (w_word == NB_DATA'(HALT_WORD));
   assign w_at_last = (r_ptr == LAST_PTR);

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (i_start)    w_next_state = ST_HI;
         ST_HI:            if (i_rx_valid) w_next_state = ST_LO;
         ST_LO: begin
            if (i_rx_valid) begin
               if (w_is_halt || w_at_last) w_next_state = ST_DONE;
               else                        w_next_state = ST_HI;
            end
         end
         default:          w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_load_start = 1'b0;
      w_latch_hi   = 1'b0;
      w_write      = 1'b0;
      w_set_error  = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         ST_IDLE: w_load_start = i_start;
         ST_HI: begin
            w_busy     = 1'b1;
            w_latch_hi = i_rx_valid;
         end
         ST_LO: begin
            w_busy      = 1'b1;
            w_write     = i_rx_valid;
            w_set_error = i_rx_valid && !w_is_halt && w_at_last;
         end
         ST_DONE: begin
            w_done       = 1'b1;
            w_load_start = i_start;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_hi_byte   <= '0;
         r_ptr       <= '0;
         r_error     <= 1'b0;
         r_wr_data   <= '0;
         r_wr_addr   <= '0;
         r_wr_enable <= 1'b0;
      end else begin
         r_wr_enable <= w_write;
         if (w_load_start) begin
            r_ptr   <= '0;
            r_error <= 1'b0;
         end
         if (w_latch_hi) r_hi_byte <= i_rx_data;
         if (w_write) begin
            r_wr_data <= w_word;
            r_wr_addr <= r_ptr[LOG2_N_INSMEM_ADDR-1:0];
            r_ptr     <= r_ptr + 1'b1;
            r_error   <= w_set_error;
         end
      end
   end

   // The pointer never wraps and starts at 0, so it doubles as the word count.
   assign o_wr_data    = r_wr_data;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_enable  = r_wr_enable;
   assign o_busy       = w_busy;
   assign o_done       = w_done;
   assign o_error      = r_error;
   assign o_word_count = r_ptr;

endmodule

// File: tb/tb_instruction_loader.sv
// Drives a full-depth loader and an 8-word loader with the same byte stream and
// checks both every cycle against a transaction-level model of the load.
module tb_instruction_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, rx_vld;
   logic [7:0] rx_dat;

   logic [15:0] wd0, wd1;
   logic [10:0] wa0;
   logic [2:0]  wa1;
   logic        we0, we1, b0, b1, d0, d1, e0, e1;
   logic [11:0] c0;
   logic [3:0]  c1;

   instruction_loader u_big (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_dat), .i_rx_valid(rx_vld),
      .o_wr_data(wd0), .o_wr_addr(wa0), .o_wr_enable(we0), .o_busy(b0), .o_done(d0),
      .o_error(e0), .o_word_count(c0));

   instruction_loader #(.N_ADDR(8)) u_small (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_dat), .i_rx_valid(rx_vld),
      .o_wr_data(wd1), .o_wr_addr(wa1), .o_wr_enable(we1), .o_busy(b1), .o_done(d1),
      .o_error(e1), .o_word_count(c1));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a load is "active" between an accepted start and its final word;
   // bytes pair up high-then-low while active.
   int depth [2] = '{2048, 8};
   bit m_act [2], m_wait_lo [2], m_done [2], m_err [2], m_we [2];
   int m_ptr [2], m_hi [2], m_wd [2], m_wa [2];
   int log_q [$];

   task automatic model_step(input int k);
      int word;
      m_we[k] = 0;
      if (rst) begin
         m_act[k] = 0; m_wait_lo[k] = 0; m_done[k] = 0; m_err[k] = 0;
         m_ptr[k] = 0; m_hi[k] = 0; m_wd[k] = 0; m_wa[k] = 0;
      end else if (!m_act[k]) begin
         if (start) begin
            m_act[k] = 1; m_wait_lo[k] = 0; m_done[k] = 0; m_err[k] = 0; m_ptr[k] = 0;
         end
      end else if (rx_vld) begin
         if (!m_wait_lo[k]) begin
            m_hi[k] = int'(rx_dat);
            m_wait_lo[k] = 1;
         end else begin
            word = m_hi[k] * 256 + int'(rx_dat);
            m_we[k] = 1; m_wd[k] = word; m_wa[k] = m_ptr[k];
            m_ptr[k]++;
            m_wait_lo[k] = 0;
            if (word == 0) begin
               m_act[k] = 0; m_done[k] = 1; m_err[k] = 0;
            end else if (m_ptr[k] == depth[k]) begin
               m_act[k] = 0; m_done[k] = 1; m_err[k] = 1;
            end
         end
      end
   endtask

   task automatic cmp(input int k, input logic we, input logic [15:0] wd, input logic [10:0] wa,
                      input logic b, input logic d, input logic e, input logic [11:0] c);
      string p;
      p = (k == 0) ? "big" : "small";
      chk({p, ".wr_enable"}, 32'(we), 32'(m_we[k]));
      chk({p, ".wr_data"},   32'(wd), 32'(m_wd[k]));
      chk({p, ".wr_addr"},   32'(wa), 32'(m_wa[k]));
      chk({p, ".busy"},      32'(b),  32'(m_act[k]));
      chk({p, ".done"},      32'(d),  32'(m_done[k]));
      chk({p, ".error"},     32'(e),  32'(m_err[k]));
      chk({p, ".word_count"},32'(c),  32'(m_ptr[k]));
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
      #1;
      cmp(0, we0, wd0, wa0, b0, d0, e0, c0);
      cmp(1, we1, wd1, {8'd0, wa1}, b1, d1, e1, {8'd0, c1});
      if (we0) log_q.push_back({5'd0, wa0, wd0});
   end

   task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] dat);
      rst = r; start = s; rx_vld = v; rx_dat = dat;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 8'($urandom));
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      idle(gap);
      drive(0, 0, 1, b);
   endtask

   task automatic send_word(input logic [15:0] w, input int maxgap);
      send(w[15:8], $urandom_range(0, maxgap));
      send(w[7:0],  $urandom_range(0, maxgap));
   endtask

   task automatic pulse_start();
      drive(0, 1, 0, 8'h00);
   endtask

   function automatic logic [15:0] nz_word();
      return 16'($urandom_range(1, 16'hFFFF));
   endfunction

   logic [7:0] pat [6] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00};

   initial begin
      rst = 1; start = 0; rx_vld = 0; rx_dat = 0;
      @(negedge clk);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      idle(1);
      chk("reset.busy", 32'(b0), 0);  chk("reset.done", 32'(d0), 0);
      chk("reset.error", 32'(e0), 0); chk("reset.count", 32'(c0), 0);
      chk("reset.wr_en", 32'(we0), 0); chk("reset.wr_data", 32'(wd0), 0);
      chk("reset.wr_addr", 32'(wa0), 0);

      // back-to-back directed load
      pulse_start();
      log_q.delete();
      for (int i = 0; i < 6; i++) send(pat[i], 0);
      idle(2);
      chk("b2b.nwrites", 32'(log_q.size()), 3);
      if (log_q.size() == 3) begin
         chk("b2b.w0", 32'(log_q[0]), 32'h0000_1234);
         chk("b2b.w1", 32'(log_q[1]), 32'h0001_ABCD);
         chk("b2b.w2", 32'(log_q[2]), 32'h0002_0000);
      end
      chk("b2b.count", 32'(c0), 3); chk("b2b.done", 32'(d0), 1);
      chk("b2b.error", 32'(e0), 0); chk("b2b.busy", 32'(b0), 0);

      // same stream with random gaps
      pulse_start();
      log_q.delete();
      for (int i = 0; i < 6; i++) send(pat[i], $urandom_range(0, 5));
      idle(3);
      chk("gap.nwrites", 32'(log_q.size()), 3);
      if (log_q.size() == 3) begin
         chk("gap.w0", 32'(log_q[0]), 32'h0000_1234);
         chk("gap.w1", 32'(log_q[1]), 32'h0001_ABCD);
         chk("gap.w2", 32'(log_q[2]), 32'h0002_0000);
      end

      // small memory fills without HALT; extra bytes must not write
      pulse_start();
      for (int i = 0; i < 8; i++) send_word(nz_word(), 2);
      idle(2);
      chk("full.error", 32'(e1), 1); chk("full.count", 32'(c1), 8);
      chk("full.done", 32'(d1), 1);  chk("full.busy", 32'(b1), 0);
      for (int i = 0; i < 4; i++) send(8'($urandom_range(1, 255)), 0);
      idle(1);
      chk("full.extra_count", 32'(c1), 8);
      send_word(16'h0000, 0);
      idle(2);

      // HALT landing on the last address is a clean finish
      pulse_start();
      for (int i = 0; i < 7; i++) send_word(nz_word(), 1);
      send_word(16'h0000, 1);
      idle(2);
      chk("halt_last.error", 32'(e1), 0); chk("halt_last.done", 32'(d1), 1);
      chk("halt_last.count", 32'(c1), 8);

      // reset mid-load, then reload from address 0
      pulse_start();
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
      drive(1, 0, 0, 0);
      idle(1);
      chk("midrst.busy", 32'(b0), 0); chk("midrst.count", 32'(c0), 0);
      chk("midrst.wr_addr", 32'(wa0), 0); chk("midrst.wr_data", 32'(wd0), 0);
      pulse_start();
      log_q.delete();
      send(8'hAA, 0); send(8'h55, 0);
      idle(2);
      chk("midrst.nwrites", 32'(log_q.size()), 1);
      if (log_q.size() == 1) chk("midrst.w0", 32'(log_q[0]), 32'h0000_AA55);
      send_word(16'h0000, 0);
      idle(2);

      // restart from DONE with just a HALT
      pulse_start();
      chk("restart.count_clr", 32'(c0), 0); chk("restart.error_clr", 32'(e0), 0);
      log_q.delete();
      send_word(16'h0000, 0);
      idle(2);
      chk("restart.nwrites", 32'(log_q.size()), 1);
      if (log_q.size() == 1) chk("restart.w0", 32'(log_q[0]), 32'h0000_0000);
      chk("restart.count", 32'(c0), 1); chk("restart.done", 32'(d0), 1);

      // bytes in IDLE ignored; start during a load ignored
      drive(1, 0, 0, 0);
      log_q.delete();
      for (int i = 0; i < 10; i++) send(8'($urandom), 0);
      idle(1);
      chk("idle.nwrites", 32'(log_q.size()), 0);
      pulse_start();
      send_word(16'h1122, 0); send_word(16'h3344, 0);
      send(8'h55, 0);
      pulse_start();
      send(8'h66, 0);
      idle(2);
      chk("midstart.nwrites", 32'(log_q.size()), 3);
      if (log_q.size() == 3) chk("midstart.w2", 32'(log_q[2]), 32'h0002_5566);
      send_word(16'h0000, 0);
      idle(2);

      // full-depth exhaustion
      pulse_start();
      for (int i = 0; i < 2048; i++) send_word(nz_word(), 0);
      idle(2);
      chk("bigfull.error", 32'(e0), 1); chk("bigfull.count", 32'(c0), 2048);
      chk("bigfull.done", 32'(d0), 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer side of the instruction memory: after a start pulse it receives a byte stream from the host link, assembles it into NB_DATA-bit instruction words (high byte first), and drives a single-cycle write port into the instruction memory bank at consecutive addresses from 0. Loading stops on the HALT word 16'h0000, which is itself written, or on address exhaustion. It sits between the UART receive path and the instruction memory, and runs while the CPU is held stalled.

## Interface
- NB_DATA, 16, instruction word width; must be 2*NB_BYTE.
- NB_BYTE, 8, width of one received byte.
- N_ADDR, 2048, instruction memory depth in words.
- LOG2_N_INSMEM_ADDR, clogb2(N_ADDR), address width.

- i_clock  in  1  clock; all state updates on posedge.
- i_reset  in  1  reset: synchronous, active-high.
- i_start  in  1  single-cycle pulse; begins a load from address 0 (accepted in IDLE or DONE only).
- i_rx_data  in  NB_BYTE  received byte; valid when i_rx_valid.
- i_rx_valid  in  1  one-cycle strobe per byte; may be asserted every cycle.
- o_wr_data  out  NB_DATA  word to write.
- o_wr_addr  out  LOG2_N_INSMEM_ADDR  write address.
- o_wr_enable  out  1  single-cycle write strobe; memory captures o_wr_data at o_wr_addr.
- o_busy  out  1  high in HI and LO states.
- o_done  out  1  high in DONE.
- o_error  out  1  set when memory fills without HALT; sticky until start/reset.
- o_word_count  out  LOG2_N_INSMEM_ADDR+1  number of words written in current load.

## Operation
- States: IDLE, HI (awaiting high byte), LO (awaiting low byte), DONE.
- IDLE: i_rx_valid ignored. i_start -> HI; write pointer=0, count=0, error=0.
- HI: i_rx_valid -> latch i_rx_data as bits [15:8], go LO.
- LO: i_rx_valid -> word = {high, i_rx_data}; register o_wr_data=word, o_wr_addr=pointer, o_wr_enable=1 for the next cycle; pointer+1, count+1.
  - word == 16'h0000 -> DONE, error=0.
  - else pointer was N_ADDR-1 -> DONE, error=1 (no wrap).
  - else -> HI.
- DONE: i_rx_valid ignored; o_done=1. i_start -> HI with pointer/count/error cleared.
- i_start in HI or LO: ignored.
- HALT written at address N_ADDR-1: DONE with error=0.
- Pointer is LOG2_N_INSMEM_ADDR+1 bits internally; never wraps.

## Timing
- Reset values: o_wr_data=0, o_wr_addr=0, o_wr_enable=0, o_busy=0, o_done=0, o_error=0, o_word_count=0; state IDLE.
- Reset mid-load: abort immediately to IDLE; a pending o_wr_enable is dropped; memory contents already written are left untouched.
- Latency: o_wr_enable is high exactly one cycle, the cycle after the low byte's i_rx_valid; o_wr_data/o_wr_addr are stable in that cycle.
- Back-to-back bytes (i_rx_valid every cycle) sustain one word per two cycles; no byte is lost, since the write strobe overlaps reception of the next high byte in HI.
- o_done, o_error, and o_word_count update in the same cycle as the final o_wr_enable.
- o_busy falls in that same cycle.
- The memory write port samples on posedge, independent of the negedge read port.

## Structure
- Shared package mips_pkg: state encoding for the loader FSM, HALT_WORD = 16'h0000, clogb2 function (shared with the instruction memory).
- No sub-module. Byte assembly and the FSM together are under 200 lines, so they live in one module.

## Test plan
- Reset, then start, then bytes 12 34 AB CD 00 00 on consecutive cycles -> writes 0x1234@0, 0xABCD@1, 0x0000@2, each strobe one cycle. o_word_count=3, o_done=1, o_error=0.
- Bytes with idle gaps of random length (0-5 cycles) -> same writes and addresses as the back-to-back case; exactly one strobe per word.
- N_ADDR=8, stream of 8 non-zero words, no HALT -> 8 writes at 0..7, then DONE with o_error=1, o_word_count=8. Extra bytes cause no write.
- Assert i_reset after 3 bytes -> all outputs 0, state IDLE. A later start plus 2 bytes writes at address 0.
- In DONE, pulse i_start and send 0x0000 -> one write 0x0000@0. o_error and o_word_count clear; then o_word_count=1, o_done=1.
- i_rx_valid in IDLE, and i_start pulsed mid-load -> no writes from IDLE bytes. The mid-load start is ignored, and the pointer continues from its current value.
